mdu_iter: RTL

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RISC-V M-extension multiply/divide unit
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   mdu_valid    request strobe, taken when mdu_ready=1
//   mdu_op[2:0]  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1, rs2     operands (multiplicand/dividend, multiplier/divisor)
//   mdu_ready    idle, can accept a request
//   mdu_done     one-cycle pulse, mdu_result valid
//   mdu_result   registered result, held until the next mdu_done
//   mdu_busy     multiply or divide in progress
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mdu_valid,
  input  logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            mdu_ready,
  output logic            mdu_done,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Request decode, evaluated on the live inputs at the accept edge.
  logic            accept;
  logic            in_signed;
  logic            in_div0;
  logic            in_ovf;
  logic            in_special;
  logic [XLEN-1:0] special_res;

  assign accept      = mdu_valid && (state_q == S_IDLE);
  assign in_signed   = ~mdu_op[0];
  assign in_div0     = (rs2 == '0);
  assign in_ovf      = in_signed && (rs1 == MIN_NEG) && (rs2 == '1);
  assign in_special  = mdu_op[2] && (in_div0 || in_ovf);

  always_comb begin
    special_res = '0;
    if (mdu_op[1]) begin
      special_res = in_div0 ? rs1 : '0;
    end else begin
      special_res = in_div0 ? '1 : MIN_NEG;
    end
  end

  // Multiplier: operands are extended to 2*XLEN so one unsigned product
  // covers the signed, mixed and unsigned variants.
  logic            mul_a_signed;
  logic            mul_b_signed;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0] mul_res;

  assign mul_a_signed = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
  assign mul_b_signed = (op_q[1:0] == 2'b01);
  assign mul_a_ext    = {{XLEN{a_q[XLEN-1] & mul_a_signed}}, a_q};
  assign mul_b_ext    = {{XLEN{b_q[XLEN-1] & mul_b_signed}}, b_q};
  assign product      = mul_a_ext * mul_b_ext;
  assign mul_res      = (op_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Restoring divider step: shift the next dividend bit into the partial
  // remainder and keep the trial subtraction when it does not borrow.
  // The partial remainder is always below the divisor, so bit XLEN of the
  // trial difference is a reliable borrow flag.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic            take;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic            q_signed;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign take      = ~trial[XLEN];
  assign rem_step  = take ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_step  = {quo_q[XLEN-2:0], take};

  // Signs come from the raw operands kept alongside the magnitudes.
  assign q_signed  = ~op_q[0];
  assign quo_fix   = (q_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_step : quo_step;
  assign rem_fix   = (q_signed && a_q[XLEN-1]) ? -rem_step : rem_step;
  assign div_res   = op_q[1] ? rem_fix : quo_fix;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = mdu_op;
          a_d   = rs1;
          b_d   = rs2;
          rem_d = '0;
          cnt_d = '0;
          quo_d = (in_signed && rs1[XLEN-1]) ? -rs1 : rs1;
          dvs_d = (in_signed && rs2[XLEN-1]) ? -rs2 : rs2;
          if (!mdu_op[2]) begin
            state_d = S_MUL;
          end else if (in_special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = mul_res;
        state_d  = S_DONE;
      end
      S_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = div_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign mdu_ready  = (state_q == S_IDLE);
  assign mdu_done   = (state_q == S_DONE);
  assign mdu_busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign mdu_result = result_q;

endmodule
